// File: rtl/eight_cpu_pkg.sv
// Shared constants and types for the 8-bit CPU memory subsystem.
// Owner encoding is shared by the arbiter and its grant picker.
package eight_cpu_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  // Burst counter increment that sticks at its maximum value.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'd15) ? value : value + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: request handshake plus read response.
interface mem_arbiter_if;
  import eight_cpu_pkg::*;

  logic                  valid;
  logic                  rw;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  lock;
  logic                  ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output valid, rw, addr, wdata, lock,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, rw, addr, wdata, lock,
    output ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: lock priority bounded by MAX_BURST, then round robin.
module mem_arb_pick
  import eight_cpu_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic [1:0] valid,
  input  owner_e     lock_owner,
  input  logic [3:0] burst_cnt,
  input  logic       last_owner,
  output logic [1:0] grant,
  output logic       force_switch
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  logic       under_limit_s;
  logic [1:0] rr_grant_s;

  assign under_limit_s = (burst_cnt < MAX_BURST_C);

  // Unlocked choice: alternate on contention, otherwise the lone requester.
  always_comb begin
    rr_grant_s = 2'b00;
    if (valid == 2'b11) begin
      rr_grant_s = last_owner ? 2'b01 : 2'b10;
    end else if (valid[0]) begin
      rr_grant_s = 2'b01;
    end else if (valid[1]) begin
      rr_grant_s = 2'b10;
    end else begin
      rr_grant_s = 2'b00;
    end
  end

  // A valid lock holder keeps the bus until its burst budget runs out under contention.
  always_comb begin
    grant        = 2'b00;
    force_switch = 1'b0;
    case (lock_owner)
      OWN_P0: begin
        if (valid[0] && (under_limit_s || !valid[1])) begin
          grant = 2'b01;
        end else if (valid[0] && valid[1]) begin
          grant        = 2'b10;
          force_switch = 1'b1;
        end else begin
          grant = rr_grant_s;
        end
      end
      OWN_P1: begin
        if (valid[1] && (under_limit_s || !valid[0])) begin
          grant = 2'b10;
        end else if (valid[0] && valid[1]) begin
          grant        = 2'b01;
          force_switch = 1'b1;
        end else begin
          grant = rr_grant_s;
        end
      end
      default: grant = rr_grant_s;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port memory: grant, bus mux and
// steering of the one-cycle read response back to the requester that issued it.
module mem_arbiter #(
  parameter int ADDR_WIDTH = eight_cpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = eight_cpu_pkg::DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          req0,
  mem_arbiter_if.slave          req1,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  logic                  last_owner_r;
  eight_cpu_pkg::owner_e lock_owner_r;
  logic [3:0]            burst_cnt_r;
  logic                  rd_pend_r;
  logic                  rd_tag_r;

  logic [1:0]            pick_grant_s;
  logic [1:0]            grant_s;
  logic                  force_switch_s;
  logic                  gnt_lock_s;
  eight_cpu_pkg::owner_e gnt_owner_s;
  logic                  rsp0_valid_s;
  logic                  rsp1_valid_s;
  logic [DATA_WIDTH-1:0] rsp0_rdata_s;
  logic [DATA_WIDTH-1:0] rsp1_rdata_s;

  mem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .valid        ({req1.valid, req0.valid}),
    .lock_owner   (lock_owner_r),
    .burst_cnt    (burst_cnt_r),
    .last_owner   (last_owner_r),
    .grant        (pick_grant_s),
    .force_switch (force_switch_s)
  );

  // Reset masks the grant so nothing reaches memory while rst is high.
  assign grant_s     = rst ? 2'b00 : pick_grant_s;
  assign req0.ready  = grant_s[0];
  assign req1.ready  = grant_s[1];
  assign gnt_lock_s  = grant_s[1] ? req1.lock : req0.lock;
  assign gnt_owner_s = grant_s[1] ? eight_cpu_pkg::OWN_P1 : eight_cpu_pkg::OWN_P0;

  // Memory bus follows the granted requester and idles at all-zero.
  always_comb begin
    mem_rw   = 1'b0;
    mem_addr = {ADDR_WIDTH{1'b0}};
    mem_data = {DATA_WIDTH{1'b0}};
    if (grant_s[0]) begin
      mem_rw   = req0.rw;
      mem_addr = req0.addr;
      mem_data = req0.wdata;
    end else if (grant_s[1]) begin
      mem_rw   = req1.rw;
      mem_addr = req1.addr;
      mem_data = req1.wdata;
    end else begin
      mem_rw   = 1'b0;
      mem_addr = {ADDR_WIDTH{1'b0}};
      mem_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Arbitration history, lock tracking and read ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_r <= 1'b1;
      lock_owner_r <= eight_cpu_pkg::OWN_NONE;
      burst_cnt_r  <= 4'd0;
      rd_pend_r    <= 1'b0;
      rd_tag_r     <= 1'b0;
    end else begin
      rd_pend_r <= (grant_s != 2'b00) && (mem_rw == eight_cpu_pkg::MEM_RD);
      rd_tag_r  <= grant_s[1];
      if (grant_s != 2'b00) begin
        last_owner_r <= grant_s[1];
        if (force_switch_s || !gnt_lock_s) begin
          lock_owner_r <= eight_cpu_pkg::OWN_NONE;
          burst_cnt_r  <= 4'd0;
        end else begin
          lock_owner_r <= gnt_owner_s;
          // A fresh lock holder starts its own count rather than inheriting one.
          burst_cnt_r  <= (lock_owner_r == gnt_owner_s) ?
                          eight_cpu_pkg::sat_inc4(burst_cnt_r) : 4'd1;
        end
      end else begin
        lock_owner_r <= eight_cpu_pkg::OWN_NONE;
        burst_cnt_r  <= 4'd0;
      end
    end
  end

  // Route registered memory data to whichever requester issued the read.
  always_comb begin
    rsp0_valid_s = 1'b0;
    rsp1_valid_s = 1'b0;
    rsp0_rdata_s = {DATA_WIDTH{1'b0}};
    rsp1_rdata_s = {DATA_WIDTH{1'b0}};
    if (rd_pend_r && !rst) begin
      if (rd_tag_r) begin
        rsp1_valid_s = 1'b1;
        rsp1_rdata_s = mem_q;
      end else begin
        rsp0_valid_s = 1'b1;
        rsp0_rdata_s = mem_q;
      end
    end else begin
      rsp0_valid_s = 1'b0;
      rsp1_valid_s = 1'b0;
    end
  end

  assign req0.rsp_valid = rsp0_valid_s;
  assign req0.rsp_rdata = rsp0_rdata_s;
  assign req1.rsp_valid = rsp1_valid_s;
  assign req1.rsp_rdata = rsp1_rdata_s;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the single-port 8-bit Von Neumann memory (`mem`).
- Requester 0 is the `control_unit` fetch/data port. Requester 1 is the debug loader / DMA port.
- Selects one requester per cycle and drives the memory bus.
- Tracks the owner of each in-flight read, so the 1-cycle registered read data returns to the correct requester.
- Supports round-robin fairness and short locked bursts, bounded by MAX_BURST.

Parameters:
- ADDR_WIDTH, 16, width of requester and memory address.
- DATA_WIDTH, 8, width of data.
- MAX_BURST, 4, maximum consecutive locked grants to one requester while the other waits (range 1..15).

Ports:
- clk  in  1  system clock; everything samples on posedge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 wants a transfer this cycle.
- req0_rw  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  address.
- req0_wdata  in  DATA_WIDTH  write data.
- req0_lock  in  1  request priority for the next cycle (burst).
- req0_ready  out  1  grant; transfer occurs at posedge when valid && ready.
- rsp0_valid  out  1  read data for requester 0 is valid this cycle.
- rsp0_rdata  out  DATA_WIDTH  read data.
- req1_valid, req1_rw, req1_addr, req1_wdata, req1_lock, req1_ready, rsp1_valid, rsp1_rdata: same as above, for requester 1.
- mem_rw  out  1  to `mem` rw.
- mem_addr  out  16  to `mem` addr.
- mem_data  out  DATA_WIDTH  to `mem` data.
- mem_q  in  DATA_WIDTH  from `mem` q, valid the cycle after a read is sampled.

Behaviour:
- Grant is combinational from the registered state plus the current valids.
  - mem_rw, mem_addr and mem_data mux from the granted requester.
  - With no grant: mem_rw = 0, mem_addr = 0, mem_data = 0. No spurious writes ever occur.
- Registered state:
  - last_owner: 1 bit.
  - lock_owner: NONE/P0/P1.
  - burst_cnt: 4 bit.
  - rd_pend: 1 bit.
  - rd_tag: 1 bit.
- Reset values: last_owner = 1 (so requester 0 wins first), lock_owner = NONE, burst_cnt = 0, rd_pend = 0.
- While rst = 1: req*_ready = 0, rsp*_valid = 0, mem_rw = 0.
- Arbitration, in priority order:
  1. If lock_owner = Px, Px is valid, and (burst_cnt < MAX_BURST or the other requester is not valid), grant Px.
  2. Otherwise, if both requesters are valid, grant the requester that is not last_owner (round robin).
  3. Otherwise, grant the single valid requester.
  4. Otherwise, grant none.
- On a granted transfer (posedge):
  - last_owner <= granted requester.
  - If the granted requester's lock = 1: lock_owner <= granted; burst_cnt <= burst_cnt + 1, saturating at 15.
  - If the granted requester's lock = 0: lock_owner <= NONE; burst_cnt <= 0.
- Forced switch:
  - Applies when the lock is overridden by the MAX_BURST limit (the other requester is granted).
  - lock_owner <= NONE and burst_cnt <= 0 in that cycle.
- If lock_owner's requester drops valid, the lock is released: lock_owner <= NONE, burst_cnt <= 0.
- Read latency is exactly 1 cycle.
  - A read granted at edge N sets rd_pend <= 1 and rd_tag <= requester.
  - In cycle N+1, rsp<rd_tag>_valid = 1 and rsp<rd_tag>_rdata = mem_q.
  - The other requester's rsp_valid = 0. rsp*_rdata is 0 when its valid is low.
- A write produces no response. The write lands at the granted posedge.
- A read granted in the cycle immediately after a write to the same address returns the new data.
- Back-to-back reads from alternating requesters return in grant order, one per cycle. Throughput is one transfer per cycle.
- rst asserted while rd_pend = 1: the pending response is dropped, and rsp*_valid = 0 in the following cycle.
- A requester must hold valid, rw, addr and wdata stable until it sees ready. Ready is never registered ahead of valid.
- Addresses are passed through unmodified as 16 bits; `mem` decodes its own depth.

Decomposition:
- Shared package eight_cpu_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH constants.
  - Owner encoding OWN_NONE = 2'd0, OWN_P0 = 2'd1, OWN_P1 = 2'd2.
  - MEM_RD = 1'b0, MEM_WR = 1'b1.
- One sub-module, mem_arb_pick:
  - Purely combinational.
  - Inputs: valids, lock_owner, burst_cnt, last_owner.
  - Outputs: a one-hot grant and a force_switch flag.
- The top-level module holds the registers, the muxing and the response steering.

Test Plan:
- Reset, then only req0 reads addr 0x0010, where mem holds 0xA5 -> req0_ready = 1 that cycle; next cycle rsp0_valid = 1 with rsp0_rdata = 0xA5; rsp1_valid = 0.
- Both valid every cycle, no lock, both reads -> grants alternate 0,1,0,1; each rsp lands 1 cycle after its grant on the matching port.
- req1 writes 0x3C to 0x0042, then req0 reads 0x0042 on the next cycle -> rsp0_rdata = 0x3C.
- req1 holds lock = 1 and valid for 8 cycles while req0 is also valid, with MAX_BURST = 4 -> req1 is granted for 4 cycles, then req0 for 1 cycle, then req1 resumes.
- Lock held by req0 with req1 idle for 20 cycles -> req0 is granted every cycle; burst_cnt saturates at 15 and no switch occurs.
- Read granted, then rst = 1 the next cycle -> rsp0_valid = 0, mem_rw = 0, all ready = 0; after rst deasserts, req0 wins the first simultaneous request.
